adder_dispatch: RTL

ADDER_DISPATCH -- requirements
Module: adder_dispatch

---
 rtl/adder_dispatch.sv | 122 ++++++++++++
 1 files changed

// File: rtl/adder_dispatch.sv
// Operand-pair FIFO in front of a byte-serial sequential adder: issues one pair
// at a time, waits for the adder's done pulse, then holds the result until taken.
module adder_dispatch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  output logic [WIDTH-1:0]             add_a,
  output logic [WIDTH-1:0]             add_b,
  output logic                         add_start,
  input  logic [WIDTH-1:0]             add_res,
  input  logic                         add_overflow,
  input  logic                         add_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_sum,
  output logic                         out_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;
  logic             valid_q;
  logic             perr_q;
  logic             push;
  logic             pop;

  // Ready is gated by reset directly so it reads 0 for the whole reset window.
  assign in_ready     = rst && (count_q != FULL);
  assign push         = in_valid && in_ready;
  assign add_start    = (state_q == IDLE) && (count_q != '0);
  assign pop          = add_start;
  assign add_a        = mem_a_q[rd_ptr_q];
  assign add_b        = mem_b_q[rd_ptr_q];
  assign out_valid    = valid_q;
  assign out_sum      = sum_q;
  assign out_overflow = ovf_q;
  assign count        = count_q;
  assign proto_err    = perr_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (add_done && (state_q != WAIT)) perr_q <= 1'b1;
      case (state_q)
        IDLE: if (add_start) state_q <= WAIT;
        WAIT: begin
          if (add_done) begin
            sum_q   <= add_res;
            ovf_q   <= add_overflow;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
